// File: rtl/uart_loader_if.sv
// ============================================================================
// Module  : uart_loader_if
// Purpose : Bus bundle between the loader, the uart_rx register port and the
//           single-master memory write port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_loader_if;
    logic        uart_cyc;
    logic        uart_addr;
    logic        uart_we;
    logic [7:0]  uart_dat;
    logic        mem_cyc;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_dat;
    logic        mem_ack;

    modport master (
        output uart_cyc, uart_addr, uart_we,
        input  uart_dat,
        output mem_cyc, mem_we, mem_addr, mem_dat,
        input  mem_ack
    );

    modport slave (
        input  uart_cyc, uart_addr, uart_we,
        output uart_dat,
        input  mem_cyc, mem_we, mem_addr, mem_dat,
        output mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/uart_loader.sv
// ============================================================================
// Module  : uart_loader
// Purpose : Polls uart_rx, parses an ADDR/CNT/data/CSUM packet and writes each
//           16-bit word to memory. Reports done or a coded error.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_loader #(
    parameter int TIMEOUT   = 25000,
    parameter int TIMEOUT_W = 16
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    input  wire logic        i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [1:0]       o_err_code,
    uart_loader_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POLL  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_HDR  = 2'd0,
        P_LO   = 2'd1,
        P_HI   = 2'd2,
        P_CSUM = 2'd3
    } phase_t;

    localparam logic [TIMEOUT_W-1:0] c_timeout_last = TIMEOUT_W'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next;
    phase_t               r_phase;
    logic [1:0]           r_hdr_idx;
    logic [7:0]           r_csum;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic                 r_started;
    logic [15:0]          r_addr;
    logic [15:0]          r_cnt;
    logic [15:0]          r_dat;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [1:0]           r_err_code;
    logic [1:0]           w_code;
    logic                 w_uart_cyc;
    logic                 w_uart_addr;
    logic                 w_timeout_hit;

    // Timeout only runs once the packet has begun, so an idle line before the
    // first byte waits indefinitely.
    assign w_timeout_hit = (TIMEOUT != 0) && r_started && (r_timeout == c_timeout_last);

    always_comb begin
        w_next      = r_state;
        w_code      = 2'd0;
        w_uart_cyc  = 1'b0;
        w_uart_addr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_POLL;
            end
            S_POLL: begin
                w_uart_cyc  = 1'b1;
                w_uart_addr = 1'b1;
                if (bus.uart_dat[1]) begin
                    w_next = S_ERR;
                    w_code = 2'd2;
                end else if (bus.uart_dat[0]) begin
                    w_next = S_READ;
                end else if (w_timeout_hit) begin
                    w_next = S_ERR;
                    w_code = 2'd1;
                end
            end
            S_READ: begin
                w_uart_cyc = 1'b1;
                case (r_phase)
                    P_HI:   w_next = S_WRITE;
                    P_CSUM: begin
                        if (bus.uart_dat == r_csum) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_ERR;
                            w_code = 2'd3;
                        end
                    end
                    default: w_next = S_POLL;
                endcase
            end
            S_WRITE: begin
                if (bus.mem_ack) w_next = S_POLL;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_phase    <= P_HDR;
            r_hdr_idx  <= 2'd0;
            r_csum     <= 8'h00;
            r_timeout  <= '0;
            r_started  <= 1'b0;
            r_addr     <= 16'h0000;
            r_cnt      <= 16'h0000;
            r_dat      <= 16'h0000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_err_code <= 2'd0;
                        r_phase    <= P_HDR;
                        r_hdr_idx  <= 2'd0;
                        r_csum     <= 8'h00;
                        r_timeout  <= '0;
                        r_started  <= 1'b0;
                    end
                end
                S_POLL: begin
                    if (!bus.uart_dat[1] && !bus.uart_dat[0] && r_started)
                        r_timeout <= r_timeout + 1'b1;
                end
                S_READ: begin
                    r_timeout <= '0;
                    r_started <= 1'b1;
                    if (r_phase != P_CSUM) r_csum <= r_csum ^ bus.uart_dat;
                    case (r_phase)
                        P_HDR: begin
                            case (r_hdr_idx)
                                2'd0:    r_addr[7:0]  <= bus.uart_dat;
                                2'd1:    r_addr[15:8] <= bus.uart_dat;
                                2'd2:    r_cnt[7:0]   <= bus.uart_dat;
                                default: r_cnt[15:8]  <= bus.uart_dat;
                            endcase
                            r_hdr_idx <= r_hdr_idx + 2'd1;
                            // CNT_H arrives now; a zero count skips straight to CSUM.
                            if (r_hdr_idx == 2'd3)
                                r_phase <= ({bus.uart_dat, r_cnt[7:0]} == 16'h0000) ? P_CSUM : P_LO;
                        end
                        P_LO: begin
                            r_dat[7:0] <= bus.uart_dat;
                            r_phase    <= P_HI;
                        end
                        P_HI: begin
                            r_dat[15:8] <= bus.uart_dat;
                            r_phase     <= P_LO;
                        end
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    if (bus.mem_ack) begin
                        r_addr <= r_addr + 16'd1;
                        r_cnt  <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) r_phase <= P_CSUM;
                    end
                end
                default: ;
            endcase
            if (w_next == S_DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if (w_next == S_ERR) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
                r_busy     <= 1'b0;
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;
    assign bus.uart_cyc  = w_uart_cyc;
    assign bus.uart_addr = w_uart_addr;
    assign bus.uart_we   = 1'b0;
    assign bus.mem_cyc   = (r_state == S_WRITE);
    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_dat   = r_dat;

endmodule

`default_nettype wire
